// File: rtl/mem_bist_pkg.sv
// Shared types and data-pattern generator for the memory BIST controller and its checkers.
// Pattern words are produced at PAT_W bits; callers size-cast them to their data width.
package mem_bist_pkg;

    localparam int PAT_W = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_WR_GAP,
        ST_RD,
        ST_RD_GAP,
        ST_DONE
    } bist_state_e;

    typedef enum logic [1:0] {
        PAT_ADDR = 2'd0,
        PAT_CHK  = 2'd1,
        PAT_INV  = 2'd2,
        PAT_ONES = 2'd3
    } bist_pat_e;

    localparam logic [PAT_W-1:0] CHK_EVEN = {8{8'h55}};
    localparam logic [PAT_W-1:0] CHK_ODD  = {8{8'hAA}};

    function automatic logic [PAT_W-1:0] bist_pattern(input logic [1:0] pattern,
                                                      input logic [31:0] addr);
        logic [PAT_W-1:0] a_ext;
        logic [PAT_W-1:0] res_w;
        a_ext = {32'd0, addr};
        case (pattern)
            PAT_ADDR: res_w = a_ext;
            PAT_CHK:  res_w = addr[0] ? CHK_ODD : CHK_EVEN;
            PAT_INV:  res_w = ~a_ext;
            default:  res_w = {PAT_W{1'b1}};
        endcase
        return res_w;
    endfunction

endpackage

// File: rtl/mem_bist_ctrl.sv
// Memory BIST master: write pass then read/compare pass over a wrapped address window.
// First request one cycle after start; each request holds until ready, then one idle gap cycle.
module mem_bist_ctrl
    import mem_bist_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  start,
    input  logic [1:0]            pattern,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   num_locs,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [ADDR_WIDTH:0]   err_cnt,
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    output logic                  valid,
    output logic                  wr_rd,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [WIDTH-1:0]      wdata,
    input  logic                  ready,
    input  logic [WIDTH-1:0]      rdata
);

    localparam int CNT_W = ADDR_WIDTH + 1;

    bist_state_e           state_q, state_nxt;
    logic [1:0]            pat_q, pat_nxt;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      idx_q, idx_nxt;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic [ADDR_WIDTH-1:0] addr_inc;
    logic [CNT_W-1:0]      cnt_clamp;
    logic [WIDTH-1:0]      exp_dat;
    logic                  last;
    logic                  xfer;

    assign cnt_clamp = (num_locs > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : num_locs;
    assign addr_inc  = (addr == ADDR_WIDTH'(DEPTH - 1)) ? '0 : addr + ADDR_WIDTH'(1);
    assign last      = (idx_q == cnt_q - CNT_W'(1));
    assign xfer      = valid && ready;
    assign exp_dat   = WIDTH'(bist_pattern(pat_q, 32'(addr)));

    always_comb begin
        state_nxt = state_q;
        addr_nxt  = addr;
        idx_nxt   = idx_q;
        pat_nxt   = pat_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pat_nxt   = pattern;
                    addr_nxt  = start_addr;
                    idx_nxt   = '0;
                    state_nxt = (cnt_clamp == '0) ? ST_DONE : ST_WR;
                end
            end
            ST_WR: begin
                if (xfer) state_nxt = ST_WR_GAP;
            end
            ST_WR_GAP: begin
                if (last) begin
                    addr_nxt  = base_q;
                    idx_nxt   = '0;
                    state_nxt = ST_RD;
                end else begin
                    addr_nxt  = addr_inc;
                    idx_nxt   = idx_q + CNT_W'(1);
                    state_nxt = ST_WR;
                end
            end
            ST_RD: begin
                if (xfer) state_nxt = ST_RD_GAP;
            end
            ST_RD_GAP: begin
                if (last) begin
                    state_nxt = ST_DONE;
                end else begin
                    addr_nxt  = addr_inc;
                    idx_nxt   = idx_q + CNT_W'(1);
                    state_nxt = ST_RD;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q        <= ST_IDLE;
            pat_q          <= '0;
            base_q         <= '0;
            cnt_q          <= '0;
            idx_q          <= '0;
            addr           <= '0;
            valid          <= 1'b0;
            wr_rd          <= 1'b0;
            wdata          <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            fail           <= 1'b0;
            err_cnt        <= '0;
            first_err_addr <= '0;
        end else begin
            state_q <= state_nxt;
            pat_q   <= pat_nxt;
            idx_q   <= idx_nxt;
            addr    <= addr_nxt;
            // Request outputs are registered from next-state so they never depend on ready/rdata.
            valid   <= (state_nxt == ST_WR) || (state_nxt == ST_RD);
            wr_rd   <= (state_nxt == ST_WR);
            wdata   <= (state_nxt == ST_WR) ? WIDTH'(bist_pattern(pat_nxt, 32'(addr_nxt))) : '0;
            busy    <= (state_nxt == ST_WR) || (state_nxt == ST_WR_GAP) ||
                       (state_nxt == ST_RD) || (state_nxt == ST_RD_GAP);
            done    <= (state_nxt == ST_DONE);

            if (state_q == ST_IDLE && start) begin
                base_q         <= start_addr;
                cnt_q          <= cnt_clamp;
                fail           <= 1'b0;
                err_cnt        <= '0;
                first_err_addr <= '0;
            end

            if (state_q == ST_RD && xfer && rdata != exp_dat) begin
                if (err_cnt != {CNT_W{1'b1}}) err_cnt <= err_cnt + CNT_W'(1);
                if (!fail) first_err_addr <= addr;
                fail <= 1'b1;
            end
        end
    end

endmodule
